// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: masks and prioritises external interrupt lines and holds one request to the core until it is acknowledged
module miriscv_irq_ctrl #(
  parameter int N_IRQ = 16,
  parameter bit EDGE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic [31:0] irq_i,
  input  logic [31:0] mie_i,
  input  logic        int_rst_i,
  output logic        interr_o,
  output logic [31:0] mcause_o
);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFFF >> (32 - N_IRQ);
  typedef enum logic [1:0] {IDLE, ACTIVE, CLEAR} state_e;
  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d, irq_prev_q, eligible, clr, mcause_q, mcause_d;
  logic [4:0]  id_q, id_d, pick;
  logic        interr_q, interr_d;
  assign eligible = (EDGE ? pend_q : irq_i) & mie_i & LINE_MASK;
  assign pend_d   = (pend_q & ~clr) | (irq_i & ~irq_prev_q);
  always_comb begin
    pick = '0;
    for (int i = 31; i >= 0; i--) if (eligible[i]) pick = 5'(i);
  end
  always_comb begin
    state_d  = state_q;
    interr_d = interr_q;
    mcause_d = mcause_q;
    id_d     = id_q;
    clr      = '0;
    case (state_q)
      IDLE: if (|eligible) begin
        id_d     = pick;
        mcause_d = {1'b1, 26'b0, pick};
        interr_d = 1'b1;
        state_d  = ACTIVE;
      end
      ACTIVE: if (int_rst_i) begin
        clr      = 32'd1 << id_q;
        interr_d = 1'b0;
        state_d  = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      irq_prev_q <= '0;
      id_q       <= '0;
      interr_q   <= 1'b0;
      mcause_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_i;
      id_q       <= id_d;
      interr_q   <= interr_d;
      mcause_q   <= mcause_d;
    end
  end
  assign interr_o = interr_q;
  assign mcause_o = mcause_q;
endmodule
